// File: rtl/led_cube_shifter.sv
// led_cube_shifter
//   Translates a whole N x N x N LED-cube frame by a signed (dx,dy,dz)
//   offset, producing one destination voxel per clock. Edge handling is
//   either wrap-around (modulo N per axis) or clip (vacated voxels filled).
//   The visible output frame only changes, atomically, when a shift ends.
//
//   Optional feature macro: LED_CUBE_SHIFTER_FILL_COLOR_EN
//     defined   : adds input fill_color, latched with the request; clip-mode
//                 vacated voxels take that colour.
//     undefined : no fill_color port; vacated voxels are black.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      shift request, sampled only while idle
//   mode       0 = wrap, 1 = clip
//   dx,dy,dz   signed offsets, range -N..N-1 (CW+1 bits)
//   frame_in   source frame, voxel i at [i*COLOR_W +: COLOR_W],
//              i = x + N*y + N*N*z
//   fill_color clip fill colour (only with the feature macro)
//   frame_out  last completed shifted frame
//   busy       high from request acceptance until the result is published
//   done       one-cycle pulse when frame_out is updated
module led_cube_shifter #(
  parameter int N       = 4,
  parameter int CW      = 2,
  parameter int COLOR_W = 24,
  parameter int VOX     = N * N * N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic [CW:0]              dx,
  input  logic [CW:0]              dy,
  input  logic [CW:0]              dz,
  input  logic [VOX*COLOR_W-1:0]   frame_in,
`ifdef LED_CUBE_SHIFTER_FILL_COLOR_EN
  input  logic [COLOR_W-1:0]       fill_color,
`endif
  output logic [VOX*COLOR_W-1:0]   frame_out,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = 3 * CW;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VOX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                   state_r;
  logic [VOX*COLOR_W-1:0]   frame_r;     // latched source frame
  logic [VOX*COLOR_W-1:0]   work_r;      // frame under construction
  logic [VOX*COLOR_W-1:0]   frame_out_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     mode_r;
  logic [CW:0]              dx_r;
  logic [CW:0]              dy_r;
  logic [CW:0]              dz_r;
  logic [CNT_W-1:0]         cnt_r;       // destination voxel index d
  logic [COLOR_W-1:0]       fill_s;

  logic [CW-1:0]            x_s;
  logic [CW-1:0]            y_s;
  logic [CW-1:0]            z_s;
  logic [CW+1:0]            sx_s;
  logic [CW+1:0]            sy_s;
  logic [CW+1:0]            sz_s;
  logic                     oob_s;
  logic [CNT_W-1:0]         src_idx_s;
  logic [COLOR_W-1:0]       src_vox_s;
  logic [COLOR_W-1:0]       new_vox_s;

`ifdef LED_CUBE_SHIFTER_FILL_COLOR_EN
  logic [COLOR_W-1:0]       fill_r;

  // Fill colour is captured with the request so later changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= '0;
    end else if (state_r == ST_LOAD) begin
      fill_r <= fill_color;
    end else begin
      fill_r <= fill_r;
    end
  end

  assign fill_s = fill_r;
`else
  assign fill_s = '0;
`endif

  // Source voxel lookup for the current destination voxel.
  always_comb begin
    x_s = cnt_r[CW-1:0];
    y_s = cnt_r[2*CW-1:CW];
    z_s = cnt_r[3*CW-1:2*CW];
    // Two extra bits: one sign, one to hold results up to 2N-1.
    sx_s = {2'b00, x_s} - {dx_r[CW], dx_r};
    sy_s = {2'b00, y_s} - {dy_r[CW], dy_r};
    sz_s = {2'b00, z_s} - {dz_r[CW], dz_r};
    // Negative (sign bit) or >= N (bit CW) means the source is off-cube.
    oob_s = sx_s[CW+1] | sx_s[CW] | sy_s[CW+1] | sy_s[CW] |
            sz_s[CW+1] | sz_s[CW];
    // Low CW bits of each coordinate are the modulo-N wrapped source.
    src_idx_s = {sz_s[CW-1:0], sy_s[CW-1:0], sx_s[CW-1:0]};
    src_vox_s = frame_r[int'(src_idx_s) * COLOR_W +: COLOR_W];
    if (mode_r && oob_s) begin
      new_vox_s = fill_s;
    end else begin
      new_vox_s = src_vox_s;
    end
  end

  // Control FSM, working buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      frame_r     <= '0;
      work_r      <= '0;
      frame_out_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mode_r      <= 1'b0;
      dx_r        <= '0;
      dy_r        <= '0;
      dz_r        <= '0;
      cnt_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          frame_r <= frame_in;
          mode_r  <= mode;
          dx_r    <= dx;
          dy_r    <= dy;
          dz_r    <= dz;
          cnt_r   <= '0;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          work_r[int'(cnt_r) * COLOR_W +: COLOR_W] <= new_vox_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // Publish the whole frame at once together with the done pulse.
          frame_out_r <= work_r;
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign frame_out = frame_out_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_led_cube_shifter.sv
// Self-checking bench for led_cube_shifter (N=4, 24-bit voxels).
// Expected frames come from a coordinate-level reference model in this file.
module tb_led_cube_shifter;

  localparam int N   = 4;
  localparam int CW  = 2;
  localparam int CWD = 24;
  localparam int VOX = N * N * N;
  localparam int LAT = VOX + 2;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 mode;
  logic [CW:0]          dx;
  logic [CW:0]          dy;
  logic [CW:0]          dz;
  logic [VOX*CWD-1:0]   frame_in;
  logic [VOX*CWD-1:0]   frame_out;
  logic                 busy;
  logic                 done;
  logic [CWD-1:0]       fill_v;

  logic [CWD-1:0]       src_v  [VOX];
  logic [CWD-1:0]       exp_v  [VOX];
  logic [CWD-1:0]       orig_v [VOX];

  int n_assert;
  int n_fail;

  led_cube_shifter #(.N(N), .CW(CW), .COLOR_W(CWD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .dx        (dx),
    .dy        (dy),
    .dz        (dz),
    .frame_in  (frame_in),
`ifdef LED_CUBE_SHIFTER_FILL_COLOR_EN
    .fill_color(fill_v),
`endif
    .frame_out (frame_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: destination (x,y,z) takes source (x-dx, y-dy, z-dz).
  task automatic model(input int m, input int dxi, input int dyi, input int dzi);
    int sx, sy, sz;
    for (int z = 0; z < N; z++)
      for (int y = 0; y < N; y++)
        for (int x = 0; x < N; x++) begin
          sx = x - dxi;
          sy = y - dyi;
          sz = z - dzi;
          if (m == 0) begin
            sx = (sx + 2 * N) % N;
            sy = (sy + 2 * N) % N;
            sz = (sz + 2 * N) % N;
            exp_v[x + N*y + N*N*z] = src_v[sx + N*sy + N*N*sz];
          end else if (sx < 0 || sx >= N || sy < 0 || sy >= N || sz < 0 || sz >= N) begin
            exp_v[x + N*y + N*N*z] = fill_v;
          end else begin
            exp_v[x + N*y + N*N*z] = src_v[sx + N*sy + N*N*sz];
          end
        end
  endtask

  task automatic drive_frame();
    for (int i = 0; i < VOX; i++) frame_in[i*CWD +: CWD] = src_v[i];
  endtask

  task automatic random_src();
    for (int i = 0; i < VOX; i++) src_v[i] = CWD'($urandom);
  endtask

  task automatic clear_src();
    for (int i = 0; i < VOX; i++) src_v[i] = '0;
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < VOX; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(frame_out[i*CWD +: CWD]), 32'(exp_v[i]));
  endtask

  // Full shift: drive, start, wait for done (bounded), compare with model.
  // poke > 0 fires a second, different start request at that cycle.
  task automatic do_shift(input string tag, input int m, input int dxi, input int dyi,
                          input int dzi, input int poke);
    int lat;
    model(m, dxi, dyi, dzi);
    drive_frame();
    mode = m[0];
    dx = dxi[CW:0];
    dy = dyi[CW:0];
    dz = dzi[CW:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (n == poke) begin
        start = 1'b1;
        mode = ~mode;
        dx = 3'd1;
        dy = 3'd2;
        dz = 3'd7;
        for (int i = 0; i < VOX; i++) frame_in[i*CWD +: CWD] = CWD'($urandom);
      end
      tick();
      start = 1'b0;
      if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check_frame(tag);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_frame({tag, "_hold"});
  endtask

  initial begin
    int dones;
    int m, a, b, c;
    n_assert = 0;
    n_fail = 0;
    fill_v = '0;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    dx = '0;
    dy = '0;
    dz = '0;
    frame_in = '0;

    // Reset state and no spontaneous done.
    repeat (3) tick();
    check("rst_frame", 32'(|frame_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_no_done", 32'(done), 32'd0);
    end

    // Wrap +X: voxel 3 moves to voxel 0.
    clear_src();
    src_v[3] = 24'hFF0000;
    do_shift("wrap_px", 0, 1, 0, 0, 0);
    check("wrap_px_v0", 32'(frame_out[0 +: CWD]), 32'h00FF0000);

    // Clip -Z: plane z=3 moves to z=2, z=0 content dropped.
    clear_src();
    src_v[48] = 24'h00FF00;
    src_v[0]  = 24'h0000FF;
    do_shift("clip_mz", 1, 0, 0, -1, 0);
    check("clip_mz_v32", 32'(frame_out[32*CWD +: CWD]), 32'h0000FF00);

    // Mixed wrap offsets, then the negated offsets restore the original.
    random_src();
    for (int i = 0; i < VOX; i++) orig_v[i] = src_v[i];
    do_shift("mix_wrap", 0, -2, 3, 1, 0);
    for (int i = 0; i < VOX; i++) src_v[i] = exp_v[i];
    do_shift("mix_undo", 0, 2, -3, -1, 0);
    for (int i = 0; i < VOX; i++) exp_v[i] = orig_v[i];
    check_frame("mix_restored");

    // Zero offset is identity in both modes.
    random_src();
    do_shift("zero_wrap", 0, 0, 0, 0, 0);
    check("zero_wrap_id", 32'(frame_out[21*CWD +: CWD]), 32'(src_v[21]));
    do_shift("zero_clip", 1, 0, 0, 0, 0);
    check("zero_clip_id", 32'(frame_out[63*CWD +: CWD]), 32'(src_v[63]));

    // Offset -N: all black in clip, identity in wrap.
    do_shift("negn_clip", 1, -4, 0, 0, 0);
    check("negn_clip_black", 32'(|frame_out), 32'd0);
    do_shift("negn_wrap", 0, -4, 0, 0, 0);
    check("negn_wrap_id", 32'(frame_out[5*CWD +: CWD]), 32'(src_v[5]));

    // Second start at cycle 10 must be ignored.
    random_src();
    do_shift("busy_prot", 0, 1, -1, 2, 10);

    // Reset at cycle 30 of a run: immediate clear, no done afterwards.
    random_src();
    drive_frame();
    mode = 1'b0;
    dx = 3'd1;
    dy = 3'd0;
    dz = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_frame", 32'(|frame_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    do_shift("after_rst", 1, 1, 2, -3, 0);

    // Randomized shifts against the model.
    for (int k = 0; k < 4; k++) begin
      random_src();
      m = int'($urandom_range(1));
      a = int'($urandom_range(7)) - 4;
      b = int'($urandom_range(7)) - 4;
      c = int'($urandom_range(7)) - 4;
      do_shift($sformatf("rand%0d", k), m, a, b, c, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
